// File: rtl/datapath_pkg.sv
// Shared datapath constants and types used by the decode/execute boundary logic.
// Immediate and word widths live here so every stage agrees on them.
package datapath_pkg;

    localparam int IMM_W  = 16;
    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

endpackage : datapath_pkg

// File: rtl/sign_extend_if.sv
// Immediate bus between the decoder and the extender: raw field in, widened operands out.
interface sign_extend_if
    import datapath_pkg::*;
#(
    parameter int IN_W  = IMM_W,
    parameter int OUT_W = WORD_W
);

    logic [IN_W-1:0]  Imm16;
    logic [OUT_W-1:0] Imm32;
    logic [OUT_W-1:0] Imm32_q;

    modport master (
        output Imm16,
        input  Imm32,
        input  Imm32_q
    );

    modport slave (
        input  Imm16,
        output Imm32,
        output Imm32_q
    );

endinterface : sign_extend_if

// File: rtl/sign_extend.sv
// Widens the instruction immediate to a datapath word (sign or zero fill) and
// provides a registered copy for pipelined consumers.
module sign_extend
    import datapath_pkg::*;
#(
    parameter int IN_W     = IMM_W,
    parameter int OUT_W    = WORD_W,
    parameter bit ZERO_EXT = 1'b0
) (
    input  logic          clk,
    input  logic          rst_n,
    sign_extend_if.slave  bus
);

    logic [OUT_W-1:0] ext;
    logic [OUT_W-1:0] extQ;

    // Equal widths need no fill; a zero-count replication is not legal.
    generate
        if (OUT_W == IN_W) begin : g_pass
            assign ext = bus.Imm16;
        end else begin : g_ext
            logic fill;
            assign fill = ZERO_EXT ? 1'b0 : bus.Imm16[IN_W-1];
            assign ext  = {{(OUT_W-IN_W){fill}}, bus.Imm16};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            extQ <= '0;
        end else begin
            extQ <= ext;
        end
    end

    assign bus.Imm32   = ext;
    assign bus.Imm32_q = extQ;

endmodule : sign_extend

// File: tb/tb_sign_extend.sv
// Directed bench for sign_extend: a sign-extending and a zero-extending instance
// driven in lockstep, with expected words queued at drive time and popped on output.
module tb_sign_extend;
    import datapath_pkg::*;

    typedef struct packed {
        word_t s;
        word_t z;
    } expPair_t;

    logic clk = 1'b0;
    logic rst_n;

    sign_extend_if #(.IN_W(IMM_W), .OUT_W(WORD_W)) sbus ();
    sign_extend_if #(.IN_W(IMM_W), .OUT_W(WORD_W)) zbus ();

    sign_extend #(.IN_W(IMM_W), .OUT_W(WORD_W), .ZERO_EXT(1'b0)) dutSign (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (sbus.slave)
    );

    sign_extend #(.IN_W(IMM_W), .OUT_W(WORD_W), .ZERO_EXT(1'b1)) dutZero (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (zbus.slave)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    expPair_t combQ[$];
    expPair_t regQ[$];

    logic [IMM_W-1:0] immTab [6] = '{16'h000A, 16'h0091, 16'h7FFF, 16'h8000, 16'h8001, 16'hFFFA};
    word_t expSTab [6] = '{32'h0000000A, 32'h00000091, 32'h00007FFF, 32'hFFFF8000, 32'hFFFF8001, 32'hFFFFFFFA};
    word_t expZTab [6] = '{32'h0000000A, 32'h00000091, 32'h00007FFF, 32'h00008000, 32'h00008001, 32'h0000FFFA};

    task automatic checkOutput(input string tag, input word_t observed, input word_t expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [IMM_W-1:0] imm, input word_t expS, input word_t expZ);
        expPair_t p;
        p.s = expS;
        p.z = expZ;
        sbus.Imm16 = imm;
        zbus.Imm16 = imm;
        combQ.push_back(p);
        regQ.push_back(p);
    endtask

    task automatic checkComb(input string tag);
        expPair_t p;
        #1;
        if (combQ.size() == 0) begin
            checkOutput({tag, "_combq_empty"}, 32'h1, 32'h0);
        end else begin
            p = combQ.pop_front();
            checkOutput({tag, "_sign"}, sbus.Imm32, p.s);
            checkOutput({tag, "_zero"}, zbus.Imm32, p.z);
            checkOutput({tag, "_signed_eq"}, sbus.Imm32, word_t'(int'($signed(sbus.Imm16))));
        end
    endtask

    task automatic checkReg(input string tag);
        expPair_t p;
        if (regQ.size() == 0) begin
            checkOutput({tag, "_regq_empty"}, 32'h1, 32'h0);
        end else begin
            p = regQ.pop_front();
            checkOutput({tag, "_q_sign"}, sbus.Imm32_q, p.s);
            checkOutput({tag, "_q_zero"}, zbus.Imm32_q, p.z);
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        word_t prevS;
        word_t prevZ;

        rst_n      = 1'b0;
        sbus.Imm16 = '0;
        zbus.Imm16 = '0;
        #3;
        checkOutput("reset_q_sign", sbus.Imm32_q, 32'h0);
        checkOutput("reset_q_zero", zbus.Imm32_q, 32'h0);

        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        prevS = 32'h0;
        prevZ = 32'h0;

        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            applyStimulus(immTab[i], expSTab[i], expZTab[i]);
            checkComb($sformatf("imm%0d", i));
            checkOutput($sformatf("imm%0d_q_hold_sign", i), sbus.Imm32_q, prevS);
            checkOutput($sformatf("imm%0d_q_hold_zero", i), zbus.Imm32_q, prevZ);
            @(posedge clk);
            #1;
            checkReg($sformatf("imm%0d", i));
            prevS = expSTab[i];
            prevZ = expZTab[i];
        end

        // Both registers now hold the 0xFFFA result; reset lands between edges.
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_q_sign", sbus.Imm32_q, 32'h0);
        checkOutput("midreset_q_zero", zbus.Imm32_q, 32'h0);
        sbus.Imm16 = 16'h7FFF;
        zbus.Imm16 = 16'h7FFF;
        #1;
        checkOutput("reset_live_sign", sbus.Imm32, 32'h00007FFF);
        checkOutput("reset_live_zero", zbus.Imm32, 32'h00007FFF);
        @(posedge clk);
        #1;
        checkOutput("reset_held_q_sign", sbus.Imm32_q, 32'h0);
        checkOutput("reset_held_q_zero", zbus.Imm32_q, 32'h0);

        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(16'h7FFF, 32'h00007FFF, 32'h00007FFF);
        checkComb("release");
        checkOutput("release_q_before_edge", sbus.Imm32_q, 32'h0);
        @(posedge clk);
        #1;
        checkReg("release");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_sign_extend

// File: doc/sign_extend.md
# sign_extend

Immediate-field extender for the datapath's decode/execute boundary. It widens the 16-bit instruction immediate `Imm16` to a 32-bit operand `Imm32` by two's-complement sign extension. The result feeds the ALU B-operand mux, the branch-offset adder and load/store address generation. A registered copy of the result is also provided for pipelined consumers.

## Interface
Parameters:
- `IN_W`, default 16: immediate input width.
- `OUT_W`, default 32: extended output width; must be greater than or equal to `IN_W`.
- `ZERO_EXT`, default 0: 1 selects zero extension instead of sign extension (elaboration-time only).

Ports:
- Clocking and reset: one clock; reset is asynchronous and active-low.
- `clk`  in  1  system clock; rising edge active.
- `rst_n`  in  1  asynchronous active-low reset.
- `Imm16`  in  `IN_W`  raw immediate field, instruction bits [15:0].
- `Imm32`  out  `OUT_W`  combinational extended immediate.
- `Imm32_q`  out  `OUT_W`  registered copy of `Imm32`.

## Operation
- `Imm32[IN_W-1:0]` = `Imm16` unchanged.
- `Imm32[OUT_W-1:IN_W]`:
  - With `ZERO_EXT`=0, every upper bit = `Imm16[IN_W-1]`.
  - With `ZERO_EXT`=1, every upper bit = 0.
- Signed value is preserved exactly for the whole range −32768..+32767. There is no saturation and no overflow case.
- If `OUT_W` == `IN_W`, the output is a plain pass-through.
- X or Z on `Imm16` propagates to the output. Nothing is masked.
- `Imm32_q` captures `Imm32` on every rising edge of `clk`. There is no enable.

## Timing
- `Imm32`: zero-cycle latency, purely combinational. It settles within the same delta as any `Imm16` change and does not depend on `clk` or `rst_n`.
- `Imm32_q`: one-cycle latency; it equals the `Imm32` value present at the preceding rising edge.
- Reset:
  - `rst_n` low forces `Imm32_q` to 0 immediately, with no wait for a clock edge.
  - While `rst_n` is low, `Imm32_q` stays 0 regardless of `Imm16`.
  - `Imm32` stays live during reset.
- Reset release: the first rising edge after `rst_n` goes high loads the current `Imm32`.
- Reset asserted mid-operation discards the held value. No partial state remains.

## Structure
- Shared package `datapath_pkg`:
  - `IMM_W` = 16 and `WORD_W` = 32 constants.
  - `word_t` typedef (32-bit logic).
- No sub-modules. The extension is a single concatenation or replication expression, and the register is one always block with async clear.

## Test plan
- Combinational, small positive values:
  - `Imm16`=0x000A → `Imm32`=0x0000000A (+10).
  - `Imm16`=0x0091 → `Imm32`=0x00000091 (+145).
- Boundary values:
  - 0x7FFF → 0x00007FFF.
  - 0x8000 → 0xFFFF8000.
  - 0x8001 → 0xFFFF8001.
- Negative value: 0xFFFA → 0xFFFFFFFA (−6). In every sign-extension case, check that `$signed(Imm32)` == `$signed(Imm16)`.
- Registered path: drive 0xFFFA before edge N → `Imm32_q`=0xFFFFFFFA after edge N, not before it.
- Reset mid-operation:
  - With `Imm32_q`=0xFFFFFFFA, pull `rst_n` low between edges → `Imm32_q`=0 at once.
  - It stays 0 while reset is held, even with `Imm16`=0x7FFF.
  - After release, the next edge gives `Imm32_q`=0x00007FFF.
- `ZERO_EXT`=1 instance: 0x8000 → 0x00008000; 0xFFFA → 0x0000FFFA.
